// File: rtl/shader_fetch_pkg.sv
// Shared definitions for the shader instruction fetch unit: opcode prefixes
// and the program loaded into instruction memory on reset.
package shader_fetch_pkg;

    localparam logic [5:0] PFX_GETX   = 6'b0001_00;
    localparam logic [5:0] PFX_GETY   = 6'b0001_01;
    localparam logic [3:0] PFX_XOR    = 4'h7;
    localparam logic [5:0] PFX_SETRGB = 6'b0000_00;
    localparam logic [1:0] PFX_LDI    = 2'b10;

    localparam int DEFAULT_LEN = 4;

    // GETX R0; GETY R1; XOR R0,R1; SETRGB R0
    localparam logic [7:0] DEFAULT_PROGRAM [DEFAULT_LEN] = '{
        {PFX_GETX, 2'd0},
        {PFX_GETY, 2'd1},
        {PFX_XOR, 2'd1, 2'd0},
        {PFX_SETRGB, 2'd0}
    };

    function automatic logic [7:0] default_instr(input int slot);
        logic [7:0] word;
        case (slot)
            0:       word = DEFAULT_PROGRAM[0];
            1:       word = DEFAULT_PROGRAM[1];
            2:       word = DEFAULT_PROGRAM[2];
            3:       word = DEFAULT_PROGRAM[3];
            default: word = 8'h00;
        endcase
        return word;
    endfunction

endpackage

// File: rtl/shader_fetch_if.sv
// Program-load and instruction-issue signals between the fetch unit and its
// surroundings (loader on the write side, execute stage on the issue side).
interface shader_fetch_if #(
  parameter int NUM_INSTR = 8,
  parameter int AW = $clog2(NUM_INSTR)
);
  logic          start_i;
  logic          wr_en_i;
  logic [AW-1:0] wr_addr_i;
  logic [7:0]    wr_data_i;
  logic [7:0]    instr_o;
  logic          execute_o;
  logic          busy_o;
  logic          done_o;
  logic          wr_ack_o;

  modport master (
    output start_i, wr_en_i, wr_addr_i, wr_data_i,
    input  instr_o, execute_o, busy_o, done_o, wr_ack_o
  );

  modport slave (
    input  start_i, wr_en_i, wr_addr_i, wr_data_i,
    output instr_o, execute_o, busy_o, done_o, wr_ack_o
  );
endinterface

// File: rtl/shader_fetch.sv
// Shader instruction fetch: on each start it streams every program slot, in
// order, to the execute stage; the program is writable only while idle.
module shader_fetch
  import shader_fetch_pkg::*;
#(
  parameter int NUM_INSTR = 8,
  localparam int AW = $clog2(NUM_INSTR)
) (
  input logic clk_i,
  input logic rst_i,
  shader_fetch_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW-1:0] LAST = AW'(NUM_INSTR - 1);

  state_t        state;
  logic [AW-1:0] pc;
  logic [7:0]    mem [NUM_INSTR];
  logic [7:0]    instr;
  logic          execute;
  logic          done;
  logic          wr_ack;

  // Slot 0 is issued in the accepting cycle so the first instruction appears
  // one cycle after start; pc therefore always names the next slot to issue.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      pc      <= '0;
      instr   <= 8'h00;
      execute <= 1'b0;
      done    <= 1'b0;
      wr_ack  <= 1'b0;
      for (int i = 0; i < NUM_INSTR; i++) begin
        mem[i] <= default_instr(i);
      end
    end else begin
      execute <= 1'b0;
      done    <= 1'b0;
      wr_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            state   <= RUN;
            instr   <= mem[0];
            execute <= 1'b1;
            pc      <= AW'(1);
          end else begin
            pc <= '0;
            if (bus.wr_en_i) begin
              mem[bus.wr_addr_i] <= bus.wr_data_i;
              wr_ack             <= 1'b1;
            end else begin
              wr_ack <= 1'b0;
            end
          end
        end
        RUN: begin
          instr   <= mem[pc];
          execute <= 1'b1;
          pc      <= pc + AW'(1);
          // start is only sampled on the final slot: it chains a gapless pass
          if (pc == LAST) begin
            done <= 1'b1;
            if (!bus.start_i) begin
              state <= IDLE;
            end else begin
              state <= RUN;
            end
          end else begin
            done <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          pc    <= '0;
        end
      endcase
    end
  end

  assign bus.instr_o   = instr;
  assign bus.execute_o = execute;
  assign bus.done_o    = done;
  assign bus.wr_ack_o  = wr_ack;
  assign bus.busy_o    = (state == RUN);

endmodule
